sect_mem_responder: RTL and testbench
=====================================

SECT_MEM_RESPONDER -- requirements
Module: sect_mem_responder

Interface
REQ-001 SHALL have parameter SECT_IDX, default 0, meaning the sector number (0..3) this instance serves, matched against address bits [12:11].
REQ-002 SHALL have parameter SECT_WORDS, default 512, meaning the number of 32-bit words (2 KiB sector).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk_i, input, 1, the rising-edge clock.
REQ-005 SHALL have port rst_i, input, 1, the asynchronous active-high reset.
REQ-006 SHALL have port sect_addr_i, input, 32, the full byte address of the request.
REQ-007 SHALL have port sect_rd_req_i, input, 1, the read request.
REQ-008 SHALL have port sect_wr_req_i, input, 1, the write request.
REQ-009 SHALL have port wr_bytemask_i, input, 4, the byte-lane write enables, already shifted to the lane.
REQ-010 SHALL have port wr_data_i, input, 32, the write data, already lane-aligned.
REQ-011 SHALL have port rdata_raw_o, output, 32, the registered read data.
REQ-012 SHALL have port busy_o, output, 1, high while the post-reset clear is in progress.
REQ-013 SHALL have port addr_err_o, output, 1, a registered one-cycle flag for a rejected request.

Function
REQ-014 SHALL form the word index from sect_addr_i[10:2]; sect_addr_i[1:0] is ignored.
REQ-015 SHALL accept a request only if sect_addr_i[31:13]==0 and sect_addr_i[12:11]==SECT_IDX.
REQ-016 SHALL have FSM states INIT and READY; reset SHALL enter INIT with the clear counter at 0.
REQ-017 SHALL, in INIT, write 32'h0 to word[counter] each cycle and increment the counter; on the cycle it writes word SECT_WORDS-1 it SHALL move to READY (SECT_WORDS cycles total).
REQ-018 SHALL drive busy_o=1 exactly while in INIT.
REQ-019 SHALL, in INIT, ignore all requests: no write, rdata_raw_o held at 0, addr_err_o=0.
REQ-020 SHALL, in READY with an accepted sect_wr_req_i, update only the bytes whose wr_bytemask_i bit is 1 at the clock edge; mask 4'b0000 SHALL be a no-op.
REQ-021 SHALL, in READY with an accepted sect_rd_req_i at edge N, present word contents on rdata_raw_o after edge N+1 (1-cycle latency).
REQ-022 SHALL hold rdata_raw_o at its last value in any cycle with no accepted read.
REQ-023 SHALL, when read and write arrive together, write the new bytes and return the pre-write (read-first) word.
REQ-024 SHALL, when a write at edge N is followed by a read of the same word at edge N+1, return the written data.
REQ-025 SHALL, for a rejected read or write request in READY, suppress the access, leave rdata_raw_o unchanged, and pulse addr_err_o for one cycle after the edge.
REQ-026 SHALL NOT raise addr_err_o when both requests are low, whatever the address.

Reset
REQ-027 SHALL, when rst_i is asserted, immediately drive rdata_raw_o=0, addr_err_o=0 and busy_o=1, and place the FSM in INIT with the counter at 0.
REQ-028 SHALL, if rst_i is asserted mid-INIT or mid-READY, restart the clear from word 0; memory contents at the reset edge SHALL NOT be relied on.
REQ-029 SHALL begin clearing on the first clock edge after rst_i is deasserted.

Verification
REQ-030 Release reset, count cycles -> busy_o is 1 for exactly 512 cycles, then 0; reading words 0, 255 and 511 returns 32'h0.
REQ-031 SECT_IDX=2; write addr 0x1004, mask 4'hF, data 0xDEADBEEF; then write mask 4'b0100, data 0x00AA0000; then read 0x1004 -> rdata_raw_o=0xDEAABEEF one cycle after the read request.
REQ-032 SECT_IDX=2; read addr 0x0804 -> addr_err_o pulses for 1 cycle and rdata_raw_o is unchanged; write to 0x2000_1004 -> rejected and memory is unchanged.
REQ-033 Word holds 0x11111111; read and write (0x22222222, mask 4'hF) in the same cycle -> returns 0x11111111; the next read returns 0x22222222.
REQ-034 Assert rst_i at clear counter 300 -> busy_o stays 1 for a further 512 cycles after deassertion, and rdata_raw_o is 0 throughout.
REQ-035 Request issued in INIT (write 0x5 to word 0) -> ignored; word 0 reads 32'h0 after READY.

Source files
------------

// File: rtl/sect_mem_responder.sv
// One 2 KiB memory sector with self-clearing after reset, byte-masked writes
// and a registered read port that returns the old word when a read and a write collide.
module sect_mem_responder #(
    parameter int SECT_IDX   = 0,
    parameter int SECT_WORDS = 512
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] sect_addr_i,
    input  logic        sect_rd_req_i,
    input  logic        sect_wr_req_i,
    input  logic [3:0]  wr_bytemask_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] rdata_raw_o,
    output logic        busy_o,
    output logic        addr_err_o
);

    localparam int AW = $clog2(SECT_WORDS);
    localparam logic [AW-1:0] LAST_WORD = AW'(SECT_WORDS - 1);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;
    logic [AW-1:0]   w_clr_cnt_nxt;
    logic [31:0]     r_mem [SECT_WORDS];
    logic [31:0]     r_rdata;
    logic            r_addr_err;

    logic [AW-1:0]   w_idx;
    logic            w_hit;
    logic            w_req;
    logic            w_clr;
    logic            w_rd_ok;
    logic            w_wr_ok;
    logic            w_err_nxt;
    logic            w_unused_addr;

    assign w_idx         = sect_addr_i[2 +: AW];
    assign w_hit         = (sect_addr_i[31:13] == 19'd0) && (sect_addr_i[12:11] == 2'(SECT_IDX));
    assign w_req         = sect_rd_req_i | sect_wr_req_i;
    assign w_unused_addr = ^sect_addr_i[1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= INIT;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr         = 1'b0;
        w_rd_ok       = 1'b0;
        w_wr_ok       = 1'b0;
        w_err_nxt     = 1'b0;
        case (r_state)
            INIT: begin
                w_clr         = 1'b1;
                w_clr_cnt_nxt = r_clr_cnt + AW'(1);
                if (r_clr_cnt == LAST_WORD) begin
                    w_state_nxt   = READY;
                    w_clr_cnt_nxt = '0;
                end
            end
            READY: begin
                w_rd_ok   = sect_rd_req_i & w_hit;
                w_wr_ok   = sect_wr_req_i & w_hit;
                w_err_nxt = w_req & ~w_hit;
            end
            default: w_state_nxt = INIT;
        endcase
    end

    // Memory has no reset; the INIT sweep is what zeroes it.
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_bytemask_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata    <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_err_nxt;
            if (w_rd_ok) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    assign rdata_raw_o = r_rdata;
    assign addr_err_o  = r_addr_err;
    assign busy_o      = (r_state == INIT);

endmodule

// File: tb/tb_sect_mem_responder.sv
// Directed and randomized checks of sect_mem_responder (SECT_IDX=2) against a
// word-array model of the sector.
module tb_sect_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  mask = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy;
    logic        err;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] ref_mem [512];
    logic [31:0] exp_rdata = '0;

    sect_mem_responder #(.SECT_IDX(2), .SECT_WORDS(512)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sect_addr_i  (addr),
        .sect_rd_req_i(rd),
        .sect_wr_req_i(wr),
        .wr_bytemask_i(mask),
        .wr_data_i    (wdata),
        .rdata_raw_o  (rdata),
        .busy_o       (busy),
        .addr_err_o   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] waddr(input int idx);
        return 32'h0000_1000 | (32'(idx) << 2);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        exp_rdata = '0;
    endtask

    // One request cycle, then one idle cycle with a random address.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [3:0] m, input logic [31:0] d, input string tag);
        bit ok;
        int idx;
        ok  = (a[31:13] == 19'd0) && (a[12:11] == 2'd2);
        idx = int'(a[10:2]);
        @(negedge clk);
        rd = r; wr = w; addr = a; mask = m; wdata = d;
        if (ok && r) exp_rdata = ref_mem[idx];
        if (ok && w)
            for (int b = 0; b < 4; b++)
                if (m[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        @(posedge clk); #1;
        chk({tag, "/rdata"}, rdata, exp_rdata);
        chk({tag, "/err"}, {31'b0, err}, {31'b0, (r | w) & ~ok});
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; addr = $urandom;
        @(posedge clk); #1;
        chk({tag, "/err_idle"}, {31'b0, err}, 32'd0);
        chk({tag, "/rdata_hold"}, rdata, exp_rdata);
    endtask

    task automatic wait_clear(input string tag);
        int n;
        bit rd_nz, err_nz;
        n = 0; rd_nz = 0; err_nz = 0;
        while (n < 2000) begin
            @(posedge clk); n++; #1;
            if (rdata !== 32'd0) rd_nz = 1;
            if (err !== 1'b0) err_nz = 1;
            if (busy !== 1'b1) break;
        end
        chk({tag, "/busy_cycles"}, n, 512);
        chk({tag, "/busy_low"}, {31'b0, busy}, 32'd0);
        chk({tag, "/rdata_zero_in_init"}, {31'b0, rd_nz}, 32'd0);
        chk({tag, "/err_zero_in_init"}, {31'b0, err_nz}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        chk({tag, "/busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "/rdata"}, rdata, 32'd0);
        chk({tag, "/err"}, {31'b0, err}, 32'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic r, w;
        logic [31:0] a;
        int sel;
        model_clear();
        #1;
        chk("por/busy", {31'b0, busy}, 32'd1);
        chk("por/rdata", rdata, 32'd0);
        chk("por/err", {31'b0, err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        // A write of 0x5 to word 0 plus a read, held throughout the clear
        rd = 1'b1; wr = 1'b1; addr = waddr(0); mask = 4'hF; wdata = 32'h5;
        rst = 1'b0;
        wait_clear("clear1");
        rd = 1'b0; wr = 1'b0;

        access(1, 0, waddr(0),   4'h0, 32'h0, "rd_w0");
        access(1, 0, waddr(255), 4'h0, 32'h0, "rd_w255");
        access(1, 0, waddr(511), 4'h0, 32'h0, "rd_w511");

        access(0, 1, 32'h0000_1004, 4'hF, 32'hDEAD_BEEF, "wr_full");
        access(0, 1, 32'h0000_1004, 4'b0100, 32'h00AA_0000, "wr_lane2");
        access(1, 0, 32'h0000_1004, 4'h0, 32'h0, "rd_merge");
        chk("merge_value", exp_rdata, 32'hDEAA_BEEF);
        access(0, 1, 32'h0000_1004, 4'h0, 32'hFFFF_FFFF, "wr_mask0");
        access(1, 0, 32'h0000_0804, 4'h0, 32'h0, "rd_wrong_sect");
        access(0, 1, 32'h2000_1004, 4'hF, 32'h1234_5678, "wr_high_bits");
        access(1, 0, 32'h0000_1004, 4'h0, 32'h0, "rd_after_reject");

        access(0, 1, waddr(5), 4'hF, 32'h1111_1111, "wr_w5");
        access(1, 1, waddr(5), 4'hF, 32'h2222_2222, "rdwr_w5");
        chk("read_first_value", exp_rdata, 32'h1111_1111);
        access(1, 0, waddr(5), 4'h0, 32'h0, "rd_w5_new");

        // Write then immediately read the same word on the next edge
        @(negedge clk);
        wr = 1'b1; addr = waddr(9); mask = 4'hF; wdata = 32'hCAFE_0009;
        ref_mem[9] = 32'hCAFE_0009;
        @(negedge clk);
        wr = 1'b0; rd = 1'b1;
        exp_rdata = 32'hCAFE_0009;
        @(posedge clk); #1;
        chk("wr_then_rd", rdata, exp_rdata);
        @(negedge clk); rd = 1'b0;

        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      a = $urandom;
            else if (sel == 1) a = {19'd0, 2'd1, 9'($urandom_range(0, 15)), 2'($urandom)};
            else               a = {19'd0, 2'd2, 9'($urandom_range(0, 15)), 2'($urandom)};
            r = 1'($urandom);
            w = 1'($urandom);
            access(r, w, a, 4'($urandom), $urandom, "rand");
        end

        do_reset("rst_ready");
        repeat (300) @(posedge clk);
        do_reset("rst_init");
        rd = 1'b1; addr = 32'h0000_0804;
        wait_clear("clear2");
        rd = 1'b0;
        access(1, 0, 32'h0000_1004, 4'h0, 32'h0, "rd_after_rst_w1");
        access(1, 0, waddr(5), 4'h0, 32'h0, "rd_after_rst_w5");
        access(1, 0, waddr(9), 4'h0, 32'h0, "rd_after_rst_w9");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
